// File: rtl/matrix_mac_sequencer.sv
// Sequences the shared ALU through a DIM x DIM signed matrix multiply C = A x B held in data memory.
// Optional feature: define MAC_SATURATE_EN to clamp accumulator overflow and raise a sticky flag.
module matrix_mac_sequencer #(
  parameter int unsigned DIM = 4,
  parameter int unsigned AW  = 8,
  parameter int unsigned DW  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW-1:0] i_base_a,
  input  logic [AW-1:0] i_base_b,
  input  logic [AW-1:0] i_base_c,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_mem_rd_en,
  output logic [AW-1:0] o_mem_rd_addr,
  input  logic [DW-1:0] i_mem_rd_data,
  output logic          o_mem_wr_en,
  output logic [AW-1:0] o_mem_wr_addr,
  output logic [DW-1:0] o_mem_wr_data,
  output logic          o_alu_own,
  output logic [5:0]    o_alu_ctrl,
  output logic [DW-1:0] o_alu_a,
  output logic [DW-1:0] o_alu_b,
  input  logic [DW-1:0] i_alu_result,
  output logic          o_sat_flag
);

  localparam int unsigned   CW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(DIM - 1);
  localparam logic [AW-1:0] DimAw   = AW'(DIM);
  localparam logic [5:0]    AluMul  = 6'b000010;
  localparam logic [5:0]    AluAdd  = 6'b000000;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StRdB  = 3'd2;
  localparam logic [2:0] StMul  = 3'd3;
  localparam logic [2:0] StAcc  = 3'd4;
  localparam logic [2:0] StWr   = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  logic [2:0]    r_state, w_state_d;
  logic [CW-1:0] r_i, r_j, r_k;
  logic [AW-1:0] r_base_a, r_base_b, r_base_c;
  logic [DW-1:0] r_a, r_prod, r_acc;

  logic          w_start_ok;
  logic          w_go;
  logic          w_last_i, w_last_j, w_last_k;
  logic [DW-1:0] w_acc_sum;

  assign w_start_ok = (r_state == StIdle) && i_start && !i_abort;
  // Strobes are suppressed in the cycle a cancel is sampled so nothing further reaches memory.
  assign w_go       = !i_abort && !i_rst;
  assign w_last_i   = (r_i == LastIdx);
  assign w_last_j   = (r_j == LastIdx);
  assign w_last_k   = (r_k == LastIdx);

`ifdef MAC_SATURATE_EN
  localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  logic w_ovf;
  logic r_sat;

  assign w_ovf     = (r_acc[DW-1] == r_prod[DW-1]) && (i_alu_result[DW-1] != r_acc[DW-1]);
  assign w_acc_sum = w_ovf ? (r_acc[DW-1] ? MinVal : MaxVal) : i_alu_result;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sat <= 1'b0;
    end else if (w_start_ok) begin
      r_sat <= 1'b0;
    end else if ((r_state == StAcc) && !i_abort && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat_flag = r_sat;
`else
  assign w_acc_sum  = i_alu_result;
  assign o_sat_flag = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_d = StRdA;
      StRdA:   w_state_d = StRdB;
      StRdB:   w_state_d = StMul;
      StMul:   w_state_d = StAcc;
      StAcc:   w_state_d = w_last_k ? StWr : StRdA;
      StWr:    w_state_d = (w_last_i && w_last_j) ? StDone : StRdA;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (i_abort) w_state_d = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_prod   <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
    end else begin
      r_state <= w_state_d;
      if (i_abort) begin
        // Leave indices clean so a later start begins at C[0][0].
        r_i   <= '0;
        r_j   <= '0;
        r_k   <= '0;
        r_acc <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start_ok) begin
              r_base_a <= i_base_a;
              r_base_b <= i_base_b;
              r_base_c <= i_base_c;
              r_i      <= '0;
              r_j      <= '0;
              r_k      <= '0;
              r_acc    <= '0;
            end
          end
          StRdB: r_a    <= i_mem_rd_data;
          StMul: r_prod <= i_alu_result;
          StAcc: begin
            r_acc <= w_acc_sum;
            if (!w_last_k) r_k <= r_k + CW'(1);
          end
          StWr: begin
            r_acc <= '0;
            r_k   <= '0;
            if (w_last_j) begin
              r_j <= '0;
              r_i <= w_last_i ? '0 : r_i + CW'(1);
            end else begin
              r_j <= r_j + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_busy        = (r_state != StIdle);
    o_done        = 1'b0;
    o_mem_rd_en   = 1'b0;
    o_mem_rd_addr = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_addr = '0;
    o_mem_wr_data = '0;
    o_alu_own     = 1'b0;
    o_alu_ctrl    = AluAdd;
    o_alu_a       = '0;
    o_alu_b       = '0;
    unique case (r_state)
      StRdA: begin
        o_mem_rd_en   = w_go;
        o_mem_rd_addr = r_base_a + AW'(r_i) * DimAw + AW'(r_k);
      end
      StRdB: begin
        o_mem_rd_en   = w_go;
        o_mem_rd_addr = r_base_b + AW'(r_k) * DimAw + AW'(r_j);
      end
      StMul: begin
        // B arrives from memory this cycle, so it feeds the ALU straight from the read port.
        o_alu_own  = 1'b1;
        o_alu_ctrl = AluMul;
        o_alu_a    = r_a;
        o_alu_b    = i_mem_rd_data;
      end
      StAcc: begin
        o_alu_own  = 1'b1;
        o_alu_ctrl = AluAdd;
        o_alu_a    = r_acc;
        o_alu_b    = r_prod;
      end
      StWr: begin
        o_mem_wr_en   = w_go;
        o_mem_wr_addr = r_base_c + AW'(r_i) * DimAw + AW'(r_j);
        o_mem_wr_data = r_acc;
      end
      StDone:  o_done = w_go;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Randomised self-checking bench for matrix_mac_sequencer (DIM=2) against a plain-arithmetic model.
module tb_matrix_mac_sequencer;

  localparam int DIM      = 2;
  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int NEL      = DIM * DIM;
  localparam int ELEM_CYC = 4 * DIM + 1;
  localparam int DONE_CYC = 1 + NEL * ELEM_CYC;
  localparam int LOG_LEN  = DONE_CYC + 8;
  localparam int BASE_A   = 0;
  localparam int BASE_B   = 4;
  localparam int BASE_C   = 8;
  localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW-1:0] base_a, base_b, base_c;
  logic          busy, done, mem_rd_en, mem_wr_en, alu_own, sat_flag;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data, alu_a, alu_b, alu_result;
  logic [5:0]    alu_ctrl;

  logic [DW-1:0] mem [256];
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [DW-1:0] tb_wdata;
  logic [AW-1:0] wr_log [$];

  int n_checks = 0;
  int n_pass   = 0;
  int mul_cnt  = 0;
  int add_cnt  = 0;
  int own_viol = 0;
  logic prev_mul = 1'b0;

  logic [DW-1:0] a_m [NEL];
  logic [DW-1:0] b_m [NEL];
  logic [DW-1:0] exp_c [NEL];
  logic          exp_sat;

  matrix_mac_sequencer #(.DIM(DIM), .AW(AW), .DW(DW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_base_a      (base_a),
    .i_base_b      (base_b),
    .i_base_c      (base_c),
    .o_busy        (busy),
    .o_done        (done),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_alu_own     (alu_own),
    .o_alu_ctrl    (alu_ctrl),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .i_alu_result  (alu_result),
    .o_sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle read latency, plus a side port for loading operands.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
      wr_log.push_back(mem_wr_addr);
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  always_comb begin
    alu_result = '0;
    if (alu_ctrl == 6'b000010)      alu_result = alu_a * alu_b;
    else if (alu_ctrl == 6'b000000) alu_result = alu_a + alu_b;
  end

  // ALU ownership protocol: MUL always followed by ADD, idle operands zero when not owned.
  always @(negedge clk) begin
    if (alu_own && alu_ctrl == 6'b000010)      mul_cnt++;
    else if (alu_own && alu_ctrl == 6'b000000) add_cnt++;
    else if (alu_own)                          own_viol++;
    if (!alu_own && (alu_ctrl != 6'd0 || alu_a != '0 || alu_b != '0)) own_viol++;
    if (prev_mul && !(alu_own && alu_ctrl == 6'b000000)) own_viol++;
    prev_mul = alu_own && (alu_ctrl == 6'b000010);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model();
    longint acc, prod;
    exp_sat = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        acc = 0;
        for (int k = 0; k < DIM; k++) begin
          prod = longint'($signed(a_m[r*DIM+k] * b_m[k*DIM+c]));
          acc  = acc + prod;
`ifdef MAC_SATURATE_EN
          if (acc > 64'sd2147483647) begin
            acc = 64'sd2147483647;
            exp_sat = 1'b1;
          end else if (acc < -64'sd2147483648) begin
            acc = -64'sd2147483648;
            exp_sat = 1'b1;
          end
`else
          acc = longint'($signed(acc[31:0]));
`endif
        end
        exp_c[r*DIM+c] = acc[31:0];
      end
    end
  endtask

  task automatic load_mem();
    for (int e = 0; e < 3 * NEL; e++) begin
      tb_we    = 1'b1;
      tb_waddr = AW'(e);
      tb_wdata = (e < NEL) ? a_m[e] : (e < 2 * NEL) ? b_m[e-NEL] : SENT;
      @(negedge clk);
    end
    tb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_mac(input string tag, input int abort_cyc, input int restart_cyc,
                         input int rst_cyc);
    int stop, done_cnt, done_first, busy_bad, strobe_after, wr_base, mul0, add0, viol0, n_wr;
    logic exp_busy;
    logic [DW-1:0] exp_v;
    stop = (abort_cyc > 0) ? abort_cyc : rst_cyc;
    done_cnt = 0; done_first = 0; busy_bad = 0; strobe_after = 0; n_wr = 0;
    load_mem();
    model();
    wr_base = wr_log.size();
    mul0 = mul_cnt; add0 = add_cnt; viol0 = own_viol;
    base_a = AW'(BASE_A); base_b = AW'(BASE_B); base_c = AW'(BASE_C);
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= LOG_LEN; cyc++) begin
      start  = (cyc == restart_cyc);
      abort  = (cyc == abort_cyc);
      rst    = (cyc == rst_cyc);
      base_a = AW'($urandom_range(0, 255));
      base_b = AW'($urandom_range(0, 255));
      base_c = AW'($urandom_range(0, 255));
      #1;
      exp_busy = (stop > 0) ? (cyc <= stop) : (cyc <= DONE_CYC);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_first == 0) done_first = cyc;
      end
      if (stop > 0 && cyc >= stop && (mem_rd_en || mem_wr_en)) strobe_after++;
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        check({tag, "_rst_ctl"}, {21'd0, busy, done, mem_rd_en, mem_wr_en, alu_own, sat_flag,
                                  alu_ctrl}, 32'd0);
        check({tag, "_rst_addr"}, {16'd0, mem_rd_addr, mem_wr_addr}, 32'd0);
        check({tag, "_rst_wdata"}, mem_wr_data, 32'd0);
        check({tag, "_rst_alu"}, alu_a | alu_b, 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    check({tag, "_busy_window"}, busy_bad, 0);
    if (stop == 0) begin
      check({tag, "_done_cycle"}, done_first, DONE_CYC);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_mul_count"}, mul_cnt - mul0, DIM * DIM * DIM);
      check({tag, "_add_count"}, add_cnt - add0, DIM * DIM * DIM);
      check({tag, "_sat_flag"}, {31'd0, sat_flag}, {31'd0, exp_sat});
    end else begin
      check({tag, "_no_done"}, done_cnt, 0);
      check({tag, "_no_strobes"}, strobe_after, 0);
    end
    check({tag, "_alu_protocol"}, own_viol - viol0, 0);
    for (int e = 0; e < NEL; e++) begin
      if (stop == 0 || ELEM_CYC * (e + 1) < stop) begin
        exp_v = exp_c[e];
        n_wr++;
      end else begin
        exp_v = SENT;
      end
      check($sformatf("%s_c%0d", tag, e), mem[BASE_C+e], exp_v);
    end
    check({tag, "_wr_count"}, wr_log.size() - wr_base, n_wr);
    for (int w = wr_base; w < wr_log.size(); w++)
      check($sformatf("%s_wr_order%0d", tag, w - wr_base), {24'd0, wr_log[w]},
            BASE_C + w - wr_base);
  endtask

  task automatic set_mats(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    a_m[0] = a0; a_m[1] = a1; a_m[2] = a2; a_m[3] = a3;
    b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tb_we = 1'b0;
    tb_waddr = '0; tb_wdata = '0;
    base_a = '0; base_b = '0; base_c = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ctl", {21'd0, busy, done, mem_rd_en, mem_wr_en, alu_own, sat_flag, alu_ctrl},
          32'd0);
    check("reset_data", mem_wr_data | alu_a | alu_b | {16'd0, mem_rd_addr, mem_wr_addr}, 32'd0);
    @(negedge clk);

    set_mats(1, 0, 0, 1, 1, 2, 3, 4);
    run_mac("ident", 0, 0, 0);
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mac("basic", 0, 0, 0);
    run_mac("abort10", 10, 0, 0);
    run_mac("after_abort", 0, 0, 0);
    run_mac("restart5", 0, 5, 0);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("start_abort_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);

    set_mats(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1, 1, 1, 1);
    run_mac("overflow", 0, 0, 0);
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mac("rst20", 0, 0, 20);
    run_mac("abort_done", DONE_CYC, 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int e = 0; e < NEL; e++) begin
        if (t < 3) begin
          a_m[e] = DW'($urandom_range(0, 30)) - 32'd15;
          b_m[e] = DW'($urandom_range(0, 30)) - 32'd15;
        end else begin
          a_m[e] = $urandom;
          b_m[e] = $urandom;
        end
      end
      run_mac($sformatf("rand%0d", t), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
